ucsbece154_icache_lru: RTL and testbench

UCSBECE154_ICACHE_LRU -- requirements
Module: ucsbece154_icache_lru

---
 rtl/ucsbece154_icache_pkg.sv | 27 ++
 rtl/ucsbece154_icache_lru_set.sv | 51 +++++
 rtl/ucsbece154_icache_lru.sv | 231 +++++++++++++++++++++++
 tb/tb_ucsbece154_icache_lru.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154_icache_pkg.sv
// rtl/ucsbece154_icache_pkg.sv - shared widths, FSM encoding and helpers for the LRU instruction cache
package ucsbece154_icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    function automatic int WORD_OFF_BITS(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int INDEX_BITS(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int TAG_BITS(input int num_sets, input int block_words);
        return 32 - 2 - WORD_OFF_BITS(block_words) - INDEX_BITS(num_sets);
    endfunction

    // Performance counters stick at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ucsbece154_icache_lru_set.sv
// rtl/ucsbece154_icache_lru_set.sv - true-LRU age update and victim choice for one cache set
module ucsbece154_icache_lru_set #(
    parameter int NUM_WAYS = 4,
    parameter int AGE_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS*AGE_W-1:0] ages_in,
    input  logic [NUM_WAYS-1:0]       valid_in,
    input  logic [AGE_W-1:0]          access_way,
    output logic [NUM_WAYS*AGE_W-1:0] ages_out,
    output logic [AGE_W-1:0]          victim
);

    logic [AGE_W-1:0] old_age;
    logic [AGE_W-1:0] max_age;
    logic             found;

    // Accessed way becomes youngest; only ways younger than it age by one, keeping a permutation
    always_comb begin
        old_age  = ages_in[access_way*AGE_W +: AGE_W];
        ages_out = ages_in;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (AGE_W'(w) == access_way) begin
                ages_out[w*AGE_W +: AGE_W] = '0;
            end else if (ages_in[w*AGE_W +: AGE_W] < old_age) begin
                ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + AGE_W'(1);
            end
        end
    end

    // Kept in its own process so the victim can feed access_way without a combinational cycle
    always_comb begin
        victim  = '0;
        found   = 1'b0;
        max_age = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_in[w] && !found) begin
                found  = 1'b1;
                victim = AGE_W'(w);
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (ages_in[w*AGE_W +: AGE_W] >= max_age) begin
                    max_age = ages_in[w*AGE_W +: AGE_W];
                    victim  = AGE_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/ucsbece154_icache_lru.sv
// rtl/ucsbece154_icache_lru.sv - set-associative instruction cache with true LRU, early restart and flush
module ucsbece154_icache_lru
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        Busy,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int OFF_W     = WORD_OFF_BITS(BLOCK_WORDS);
    localparam int IDX_W     = INDEX_BITS(NUM_SETS);
    localparam int TAG_W     = TAG_BITS(NUM_SETS, BLOCK_WORDS);
    localparam int AGE_W     = $clog2(NUM_WAYS);
    localparam int LOW_W     = 2 + OFF_W;
    localparam int SET_AGE_W = NUM_WAYS * AGE_W;

    state_t              state_q, state_d;
    logic                flush_pend_q, flush_pend_d;
    logic                ready_q, ready_d;
    logic [31:0]         instr_q, instr_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;
    logic [OFF_W-1:0]    word_cnt_q, word_cnt_d;
    logic [OFF_W-1:0]    req_off_q, req_off_d;
    logic [IDX_W-1:0]    req_idx_q, req_idx_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic [31:0]         line_q [BLOCK_WORDS];
    logic [31:0]         line_d [BLOCK_WORDS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
    logic [SET_AGE_W-1:0] age_q [NUM_SETS];
    logic [SET_AGE_W-1:0] age_d [NUM_SETS];

    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [31:0]         data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    logic [OFF_W-1:0]    a_off;
    logic [IDX_W-1:0]    a_idx;
    logic [TAG_W-1:0]    a_tag;
    logic                unused_byte_bits;

    assign a_off            = ReadAddress[LOW_W-1:2];
    assign a_idx            = ReadAddress[LOW_W+IDX_W-1:LOW_W];
    assign a_tag            = ReadAddress[31:LOW_W+IDX_W];
    assign unused_byte_bits = ^ReadAddress[1:0];

    logic             hit;
    logic [AGE_W-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[a_idx][w] && (tag_mem[a_idx][w] == a_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // One LRU unit serves the looked-up set in IDLE and the latched set during refill
    logic                 in_idle;
    logic [IDX_W-1:0]     lru_idx;
    logic [AGE_W-1:0]     lru_access;
    logic [AGE_W-1:0]     victim;
    logic [SET_AGE_W-1:0] lru_ages;

    assign in_idle    = (state_q == S_IDLE);
    assign lru_idx    = in_idle ? a_idx : req_idx_q;
    assign lru_access = in_idle ? hit_way : victim;

    ucsbece154_icache_lru_set #(
        .NUM_WAYS (NUM_WAYS)
    ) u_lru_set (
        .ages_in    (age_q[lru_idx]),
        .valid_in   (valid_q[lru_idx]),
        .access_way (lru_access),
        .ages_out   (lru_ages),
        .victim     (victim)
    );

    logic fill_we;
    logic last_word;

    assign last_word = (word_cnt_q == {OFF_W{1'b1}});

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        ready_d      = 1'b0;
        instr_d      = instr_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        word_cnt_d   = word_cnt_q;
        req_off_d    = req_off_q;
        req_idx_d    = req_idx_q;
        req_tag_d    = req_tag_q;
        line_d       = line_q;
        valid_d      = valid_q;
        age_d        = age_q;
        fill_we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Flush) begin
                    state_d = S_FLUSH;
                end else if (ReadEnable && hit) begin
                    ready_d       = 1'b1;
                    instr_d       = data_mem[a_idx][hit_way][a_off];
                    age_d[a_idx]  = lru_ages;
                    hit_cnt_d     = sat_inc(hit_cnt_q);
                end else if (ReadEnable) begin
                    state_d    = S_REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {ReadAddress[31:LOW_W], {LOW_W{1'b0}}};
                    req_off_d  = a_off;
                    req_idx_d  = a_idx;
                    req_tag_d  = a_tag;
                    word_cnt_d = '0;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                end
            end
            S_REFILL: begin
                if (Flush) begin
                    flush_pend_d = 1'b1;
                end
                if (MemDataReady) begin
                    line_d[word_cnt_q] = MemDataIn;
                    word_cnt_d         = word_cnt_q + OFF_W'(1);
                    if (word_cnt_q == req_off_q) begin
                        ready_d = 1'b1;
                        instr_d = MemDataIn;
                    end
                    if (last_word) begin
                        fill_we                    = 1'b1;
                        valid_d[req_idx_q][victim] = 1'b1;
                        age_d[req_idx_q]           = lru_ages;
                        mem_req_d                  = 1'b0;
                        state_d = (flush_pend_q || Flush) ? S_FLUSH : S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_d[s] = '0;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            instr_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            word_cnt_q   <= '0;
            req_off_q    <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            ready_q      <= ready_d;
            instr_q      <= instr_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            word_cnt_q   <= word_cnt_d;
            req_off_q    <= req_off_d;
            req_idx_q    <= req_idx_d;
            req_tag_q    <= req_tag_d;
            line_q       <= line_d;
            valid_q      <= valid_d;
            age_q        <= age_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone decide whether a line exists
    always_ff @(posedge Clk) begin
        if (fill_we && !Reset) begin
            tag_mem[req_idx_q][victim] <= req_tag_q;
            for (int b = 0; b < BLOCK_WORDS; b++) begin
                data_mem[req_idx_q][victim][b] <= line_d[b];
            end
        end
    end

    assign Instruction    = instr_q;
    assign Ready          = ready_q;
    assign Busy           = (state_q != S_IDLE);
    assign MemReadAddress = mem_addr_q;
    assign MemReadRequest = mem_req_q;
    assign HitCount       = hit_cnt_q;
    assign MissCount      = miss_cnt_q;

endmodule

// File: tb/tb_ucsbece154_icache_lru.sv
// tb/tb_ucsbece154_icache_lru.sv - self-checking bench for the LRU instruction cache
module tb_ucsbece154_icache_lru;

    localparam int BW = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadAddress = '0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn = '0;
    logic        MemDataReady = 1'b0;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference: per set, a recency-ordered list of resident tags (slot 0 = most recent)
    logic [24:0] mtag [8][4];
    int          mcnt [8];
    int          m_hits;
    int          m_misses;

    ucsbece154_icache_lru dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Flush          (Flush),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .Busy           (Busy),
        .MemReadAddress (MemReadAddress),
        .MemReadRequest (MemReadRequest),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady),
        .HitCount       (HitCount),
        .MissCount      (MissCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] aw;
        aw = {a[31:2], 2'b00};
        if (aw[31:4] == 28'h0000010) return 32'hA0 + {28'd0, aw[3:2]};
        return aw ^ 32'h5EED_0000 ^ {aw[15:0], aw[31:16]};
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 8; s++) mcnt[s] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int          s;
        int          pos;
        logic [24:0] t;
        bit          h;
        s   = int'(a[6:4]);
        t   = a[31:7];
        pos = -1;
        for (int i = 0; i < mcnt[s]; i++) if (mtag[s][i] == t) pos = i;
        h = (pos >= 0);
        if (!h) begin
            if (mcnt[s] < 4) mcnt[s]++;
            pos = mcnt[s] - 1;
        end
        for (int i = pos; i > 0; i--) mtag[s][i] = mtag[s][i-1];
        mtag[s][0] = t;
        return h;
    endfunction

    task automatic apply_reset();
        Reset = 1'b1; ReadEnable = 1'b0; Flush = 1'b0; MemDataReady = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_clear();
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input bit flush_mid, output bit was_hit);
        bit          exp_hit, flushed, req_held;
        int          i, guard, readies, ready_after;
        logic [31:0] blk, rword, want;
        blk  = {addr[31:4], 4'h0};
        want = mem_word(addr);
        exp_hit = model_access(addr);
        if (exp_hit) m_hits++; else m_misses++;
        ReadEnable = 1'b1; ReadAddress = addr;
        @(negedge Clk);
        ReadEnable = 1'b0;
        was_hit = (Ready === 1'b1);
        n_cmp++;
        if (Ready !== exp_hit) begin
            n_fail++; $display("FAIL hit_class addr=%h: got Ready=%b want %b", addr, Ready, exp_hit);
        end
        if (Ready === 1'b1) begin
            n_cmp++;
            if (Instruction !== want || Busy !== 1'b0) begin
                n_fail++; $display("FAIL hit_data addr=%h: got %h busy=%b want %h busy=0", addr, Instruction, Busy, want);
            end
        end else begin
            n_cmp++;
            if (Busy !== 1'b1 || MemReadRequest !== 1'b1 || MemReadAddress !== blk) begin
                n_fail++; $display("FAIL miss_start addr=%h: got busy=%b req=%b maddr=%h want 1 1 %h", addr, Busy, MemReadRequest, MemReadAddress, blk);
            end
            i = 0; guard = 0; readies = 0; ready_after = -1; rword = '0; flushed = 0; req_held = 1;
            while (i < BW && guard < 64) begin
                if (Ready === 1'b1) begin readies++; ready_after = i; rword = Instruction; end
                if (MemReadRequest !== 1'b1) req_held = 0;
                Flush = flush_mid && (i == 1) && !flushed;
                if (Flush) flushed = 1;
                ReadEnable  = ($urandom_range(0, 3) == 0);
                ReadAddress = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    MemDataReady = 1'b0;
                end else begin
                    MemDataReady = 1'b1;
                    MemDataIn    = mem_word(blk + 32'(4 * i));
                    i++;
                end
                guard++;
                @(negedge Clk);
            end
            MemDataReady = 1'b0; ReadEnable = 1'b0; Flush = 1'b0;
            if (Ready === 1'b1) begin readies++; ready_after = i; rword = Instruction; end
            n_cmp++;
            if (i != BW) begin n_fail++; $display("FAIL refill_timeout addr=%h: got %0d words want %0d", addr, i, BW); end
            n_cmp++;
            if (readies != 1 || ready_after != int'(addr[3:2]) + 1 || rword !== want) begin
                n_fail++; $display("FAIL early_restart addr=%h: got %0d pulses after %0d words data %h want 1 after %0d data %h",
                                   addr, readies, ready_after, rword, int'(addr[3:2]) + 1, want);
            end
            n_cmp++;
            if (!req_held) begin n_fail++; $display("FAIL req_held addr=%h: got request drop want held", addr); end
            if (flush_mid) begin
                n_cmp++;
                if (Busy !== 1'b1 || MemReadRequest !== 1'b0) begin
                    n_fail++; $display("FAIL flush_after_refill: got busy=%b req=%b want 1 0", Busy, MemReadRequest);
                end
                @(negedge Clk);
                n_cmp++;
                if (Busy !== 1'b0 || Ready !== 1'b0) begin
                    n_fail++; $display("FAIL flush_done: got busy=%b ready=%b want 0 0", Busy, Ready);
                end
                model_clear();
            end else begin
                n_cmp++;
                if (Busy !== 1'b0 || MemReadRequest !== 1'b0) begin
                    n_fail++; $display("FAIL refill_done: got busy=%b req=%b want 0 0", Busy, MemReadRequest);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({Busy, Ready, MemReadRequest} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {Busy, Ready, MemReadRequest});
        end
        n_cmp++;
        if (MemReadAddress !== 32'h0 || Instruction !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got maddr=%h instr=%h want 0 0", MemReadAddress, Instruction);
        end
        n_cmp++;
        if (HitCount !== 32'h0 || MissCount !== 32'h0) begin
            n_fail++; $display("FAIL reset_counts: got %0d %0d want 0 0", HitCount, MissCount);
        end
    endtask

    task automatic test_cold_miss();
        bit h;
        do_read(32'h0000_0104, 0, h);
        n_cmp++;
        if (h !== 1'b0 || MissCount !== 32'd1) begin
            n_fail++; $display("FAIL cold_miss: got hit=%b misses=%0d want 0 1", h, MissCount);
        end
    endtask

    task automatic test_back_to_back();
        bit h;
        h = model_access(32'h104); if (h) m_hits++; else m_misses++;
        h = model_access(32'h10C); if (h) m_hits++; else m_misses++;
        ReadEnable = 1'b1; ReadAddress = 32'h0000_0104;
        @(negedge Clk);
        n_cmp++;
        if (Ready !== 1'b1 || Instruction !== 32'hA1 || MemReadRequest !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got ready=%b instr=%h req=%b want 1 a1 0", Ready, Instruction, MemReadRequest);
        end
        ReadAddress = 32'h0000_010C;
        @(negedge Clk);
        ReadEnable = 1'b0;
        n_cmp++;
        if (Ready !== 1'b1 || Instruction !== 32'hA3 || MemReadRequest !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: got ready=%b instr=%h req=%b busy=%b want 1 a3 0 0", Ready, Instruction, MemReadRequest, Busy);
        end
        n_cmp++;
        if (HitCount !== 32'd2) begin n_fail++; $display("FAIL b2b_hitcount: got %0d want 2", HitCount); end
    endtask

    task automatic test_lru_evict();
        logic [31:0] seq [8];
        bit          exp [8];
        bit          h;
        seq = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h000, 32'h200, 32'h000, 32'h080};
        exp = '{0, 0, 1, 0, 1, 0, 1, 0};
        for (int k = 0; k < 8; k++) begin
            do_read(seq[k], 0, h);
            n_cmp++;
            if (h !== exp[k]) begin
                n_fail++; $display("FAIL lru_seq step %0d addr=%h: got hit=%b want %b", k, seq[k], h, exp[k]);
            end
        end
    endtask

    task automatic test_flush_mid_refill();
        bit h;
        do_read(32'h0000_0344, 1, h);
        do_read(32'h0000_0344, 0, h);
        n_cmp++;
        if (h !== 1'b0) begin n_fail++; $display("FAIL flush_mid_reread: got hit=%b want 0", h); end
    endtask

    task automatic test_flush_idle();
        bit h;
        logic [31:0] hits_before;
        hits_before = HitCount;
        Flush = 1'b1; ReadEnable = 1'b1; ReadAddress = 32'h0000_0344;
        @(negedge Clk);
        Flush = 1'b0; ReadEnable = 1'b0;
        n_cmp++;
        if (Busy !== 1'b1 || Ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_busy: got busy=%b ready=%b want 1 0", Busy, Ready);
        end
        @(negedge Clk);
        n_cmp++;
        if (Busy !== 1'b0 || HitCount !== hits_before) begin
            n_fail++; $display("FAIL flush_idle_end: got busy=%b hits=%0d want 0 %0d", Busy, HitCount, hits_before);
        end
        model_clear();
        do_read(32'h0000_0344, 0, h);
        n_cmp++;
        if (h !== 1'b0) begin n_fail++; $display("FAIL flush_idle_reread: got hit=%b want 0", h); end
    endtask

    task automatic test_reset_mid_refill();
        bit h;
        ReadEnable = 1'b1; ReadAddress = 32'h0000_0454;
        @(negedge Clk);
        ReadEnable = 1'b0;
        MemDataReady = 1'b1; MemDataIn = mem_word(32'h450);
        @(negedge Clk);
        MemDataIn = mem_word(32'h454); Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; MemDataReady = 1'b0;
        n_cmp++;
        if ({Busy, Ready, MemReadRequest} !== 3'b000 || MemReadAddress !== 32'h0 || Instruction !== 32'h0 ||
            HitCount !== 32'h0 || MissCount !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got busy=%b ready=%b req=%b maddr=%h instr=%h hits=%0d misses=%0d want all 0",
                               Busy, Ready, MemReadRequest, MemReadAddress, Instruction, HitCount, MissCount);
        end
        model_clear(); m_hits = 0; m_misses = 0;
        for (int k = 0; k < 3; k++) begin
            MemDataReady = 1'b1; MemDataIn = mem_word(32'h458 + 32'(4 * k));
            @(negedge Clk);
            n_cmp++;
            if (Busy !== 1'b0 || Ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid_stray %0d: got busy=%b ready=%b want 0 0", k, Busy, Ready);
            end
        end
        MemDataReady = 1'b0;
        do_read(32'h0000_0454, 0, h);
        n_cmp++;
        if (h !== 1'b0 || MissCount !== 32'd1) begin
            n_fail++; $display("FAIL reset_mid_reread: got hit=%b misses=%0d want 0 1", h, MissCount);
        end
    endtask

    task automatic test_random();
        bit          h;
        int          r;
        logic [31:0] a;
        apply_reset();
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                Flush = 1'b1; ReadEnable = 1'($urandom_range(0, 1)); ReadAddress = $urandom;
                @(negedge Clk);
                Flush = 1'b0; ReadEnable = 1'b0;
                n_cmp++;
                if (Busy !== 1'b1 || Ready !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_flush_busy: got busy=%b ready=%b want 1 0", Busy, Ready);
                end
                @(negedge Clk);
                n_cmp++;
                if (Busy !== 1'b0) begin n_fail++; $display("FAIL rnd_flush_end: got busy=%b want 0", Busy); end
                model_clear();
            end else if (r == 1) begin
                MemDataReady = 1'b1; MemDataIn = $urandom;
                @(negedge Clk);
                MemDataReady = 1'b0;
                n_cmp++;
                if (Busy !== 1'b0 || Ready !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_stray_data: got busy=%b ready=%b want 0 0", Busy, Ready);
                end
            end else begin
                a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 1)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                do_read(a, ($urandom_range(0, 9) == 0), h);
            end
        end
        n_cmp++;
        if (HitCount !== 32'(m_hits) || MissCount !== 32'(m_misses)) begin
            n_fail++; $display("FAIL rnd_counters: got hits=%0d misses=%0d want %0d %0d", HitCount, MissCount, m_hits, m_misses);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_lru_evict();
        test_flush_mid_refill();
        test_flush_idle();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
